adc_sequencer: RTL and testbench



---
 rtl/adc_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_adc_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sequencer.sv
// Round-robin ADC command issuer with per-channel power-of-two averaging and a
// first-word-fall-through output FIFO. Define ADC_SEQUENCER_PEAK_EN to report per-window peaks.
module adc_sequencer #(
    parameter int NUM_CHANNELS    = 4,
    parameter int FIRST_CHANNEL   = 1,
    parameter int AVG_LOG2        = 4,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    output logic        command_valid_out,
    output logic [4:0]  command_channel_out,
    output logic        command_startofpacket_out,
    output logic        command_endofpacket_out,
    input  logic        command_ready_in,
    input  logic        response_valid_in,
    input  logic [4:0]  response_channel_in,
    input  logic [11:0] response_data_in,
    output logic [31:0] adc_out,
    output logic        adc_stb_out,
    input  logic        adc_ack_in,
    output logic        overflow_out
);

    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int PTR_W = FIFO_DEPTH_LOG2;
    localparam int OCC_W = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHANNELS - 1);

    // ---------------- command side ----------------
    logic             cmd_valid_q;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (cmd_valid_q && command_ready_in) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid_q <= 1'b0;
            idx_q       <= '0;
        end else begin
            cmd_valid_q <= 1'b1;
            idx_q       <= idx_d;
        end
    end

    assign command_valid_out         = cmd_valid_q;
    assign command_channel_out       = 5'(FIRST_CHANNEL) + 5'(idx_q);
    assign command_startofpacket_out = (idx_q == '0);
    assign command_endofpacket_out   = (idx_q == IDX_LAST);

    // ---------------- response accumulation ----------------
    // Borrow out of the subtraction lands in bit 5, so one compare covers both range ends.
    logic [5:0]       rsp_off;
    logic             rsp_use;
    logic [IDX_W-1:0] rsp_idx;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] sum_shift;
    logic             complete;
    logic [11:0]      word_peak;
    logic [31:0]      word;

    logic [ACC_W-1:0] acc_q [NUM_CHANNELS];
    logic [CNT_W-1:0] cnt_q [NUM_CHANNELS];

    assign rsp_off   = {1'b0, response_channel_in} - 6'(FIRST_CHANNEL);
    assign rsp_use   = response_valid_in && (rsp_off < 6'(NUM_CHANNELS));
    assign rsp_idx   = rsp_off[IDX_W-1:0];
    assign sum       = acc_q[rsp_idx] + ACC_W'(response_data_in);
    assign sum_shift = sum >> AVG_LOG2;
    assign complete  = rsp_use && (cnt_q[rsp_idx] == CNT_LAST);

`ifdef ADC_SEQUENCER_PEAK_EN
    logic [11:0] peak_q [NUM_CHANNELS];
    logic [11:0] peak_new;

    assign peak_new  = (response_data_in > peak_q[rsp_idx]) ? response_data_in : peak_q[rsp_idx];
    assign word_peak = peak_new;
`else
    assign word_peak = 12'd0;
`endif

    assign word = {response_channel_in, 1'b0, 2'b00, word_peak, sum_shift[11:0]};

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            logic hit;
            assign hit = rsp_use && (rsp_idx == IDX_W'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_q[gi] <= '0;
                    cnt_q[gi] <= '0;
                end else if (hit) begin
                    acc_q[gi] <= complete ? '0 : sum;
                    cnt_q[gi] <= complete ? '0 : cnt_q[gi] + CNT_W'(1);
                end
            end

`ifdef ADC_SEQUENCER_PEAK_EN
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    peak_q[gi] <= '0;
                end else if (hit) begin
                    peak_q[gi] <= complete ? 12'd0 : peak_new;
                end
            end
`endif
        end
    endgenerate

    // Completed word is staged one cycle before entering the FIFO.
    logic        push_q;
    logic [31:0] push_word_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_q      <= 1'b0;
            push_word_q <= '0;
        end else begin
            push_q <= complete;
            if (complete) begin
                push_word_q <= word;
            end
        end
    end

    // ---------------- output FIFO ----------------
    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             ovf_q, ovf_d;
    logic             empty, full, pop, wr, drop;

    assign empty = (occ_q == '0);
    assign full  = (occ_q == OCC_W'(DEPTH));
    assign pop   = !empty && adc_ack_in;
    assign wr    = push_q && (!full || pop);
    assign drop  = push_q && full && !pop;

    always_comb begin
        occ_d = occ_q;
        if (wr && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !wr) begin
            occ_d = occ_q - OCC_W'(1);
        end
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (pop) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            occ_q <= occ_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr_q] <= push_word_q;
        end
    end

    assign adc_stb_out  = !empty;
    assign adc_out      = empty ? 32'd0 : (mem[rd_ptr_q] | {5'd0, ovf_q, 26'd0});
    assign overflow_out = ovf_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer: vector table for command scan and a first window,
// hand sequences for ignored channels, FIFO overflow, full push/pop, reset and peak.
module tb_adc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        command_valid_out;
    logic [4:0]  command_channel_out;
    logic        command_startofpacket_out;
    logic        command_endofpacket_out;
    logic        command_ready_in;
    logic        response_valid_in;
    logic [4:0]  response_channel_in;
    logic [11:0] response_data_in;
    logic [31:0] adc_out;
    logic        adc_stb_out;
    logic        adc_ack_in;
    logic        overflow_out;

    int checks = 0;
    int errors = 0;

`ifdef ADC_SEQUENCER_PEAK_EN
    localparam bit PEAK = 1'b1;
`else
    localparam bit PEAK = 1'b0;
`endif

    adc_sequencer #(
        .NUM_CHANNELS(4),
        .FIRST_CHANNEL(1),
        .AVG_LOG2(2),
        .FIFO_DEPTH_LOG2(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .command_valid_out(command_valid_out),
        .command_channel_out(command_channel_out),
        .command_startofpacket_out(command_startofpacket_out),
        .command_endofpacket_out(command_endofpacket_out),
        .command_ready_in(command_ready_in),
        .response_valid_in(response_valid_in),
        .response_channel_in(response_channel_in),
        .response_data_in(response_data_in),
        .adc_out(adc_out),
        .adc_stb_out(adc_stb_out),
        .adc_ack_in(adc_ack_in),
        .overflow_out(overflow_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [4:0]  rch;
        logic [11:0] rd;
        logic        ack;
        logic        e_vld;
        logic [4:0]  e_ch;
        logic        e_sop;
        logic        e_eop;
        logic        e_stb;
        logic [31:0] e_out;
        logic        e_ovf;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [4:0] rch,
                                input logic [11:0] rd, input logic ack, input logic e_vld,
                                input logic [4:0] e_ch, input logic e_sop, input logic e_eop,
                                input logic e_stb, input logic [31:0] e_out, input logic e_ovf);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rch = rch; v.rd = rd; v.ack = ack;
        v.e_vld = e_vld; v.e_ch = e_ch; v.e_sop = e_sop; v.e_eop = e_eop;
        v.e_stb = e_stb; v.e_out = e_out; v.e_ovf = e_ovf;
        return v;
    endfunction

    function automatic logic [11:0] pk(input int x);
        return PEAK ? 12'(x) : 12'd0;
    endfunction

    function automatic logic [31:0] word(input logic [4:0] ch, input logic ovf,
                                         input logic [11:0] peak, input int mean);
        return {ch, ovf, 2'b00, peak, 12'(mean)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input logic rdy, input logic rv, input logic [4:0] ch,
                        input logic [11:0] d, input logic ack);
        command_ready_in    = rdy;
        response_valid_in   = rv;
        response_channel_in = ch;
        response_data_in    = d;
        adc_ack_in          = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic window(input logic [4:0] ch, input int d0, input int d1,
                          input int d2, input int d3);
        step(1'b0, 1'b1, ch, 12'(d0), 1'b0);
        step(1'b0, 1'b1, ch, 12'(d1), 1'b0);
        step(1'b0, 1'b1, ch, 12'(d2), 1'b0);
        step(1'b0, 1'b1, ch, 12'(d3), 1'b0);
    endtask

    task automatic idle(input logic ack);
        step(1'b0, 1'b0, 5'd0, 12'd0, ack);
    endtask

    initial begin
        logic [31:0] w1;
        int v;
        w1 = word(5'd2, 1'b0, pk(104), (100 + 101 + 102 + 104) >> 2);

        //              rdy rv  rch    rd       ack  vld ch     sop  eop  stb  out  ovf
        tbl[0]  = mk(1, 0, 5'd0, 12'd0,   0,   1, 5'd1, 1, 0, 0, 32'd0, 0);
        tbl[1]  = mk(1, 0, 5'd0, 12'd0,   0,   1, 5'd2, 0, 0, 0, 32'd0, 0);
        tbl[2]  = mk(1, 0, 5'd0, 12'd0,   0,   1, 5'd3, 0, 0, 0, 32'd0, 0);
        tbl[3]  = mk(1, 0, 5'd0, 12'd0,   0,   1, 5'd4, 0, 1, 0, 32'd0, 0);
        tbl[4]  = mk(1, 0, 5'd0, 12'd0,   0,   1, 5'd1, 1, 0, 0, 32'd0, 0);
        tbl[5]  = mk(1, 0, 5'd0, 12'd0,   0,   1, 5'd2, 0, 0, 0, 32'd0, 0);
        tbl[6]  = mk(0, 0, 5'd0, 12'd0,   0,   1, 5'd2, 0, 0, 0, 32'd0, 0);
        tbl[7]  = mk(0, 1, 5'd2, 12'd100, 1,   1, 5'd2, 0, 0, 0, 32'd0, 0);
        tbl[8]  = mk(0, 1, 5'd2, 12'd101, 1,   1, 5'd2, 0, 0, 0, 32'd0, 0);
        tbl[9]  = mk(0, 0, 5'd2, 12'd555, 1,   1, 5'd2, 0, 0, 0, 32'd0, 0);
        tbl[10] = mk(0, 1, 5'd2, 12'd102, 1,   1, 5'd2, 0, 0, 0, 32'd0, 0);
        tbl[11] = mk(0, 1, 5'd2, 12'd104, 1,   1, 5'd2, 0, 0, 0, 32'd0, 0);
        tbl[12] = mk(0, 0, 5'd0, 12'd0,   0,   1, 5'd2, 0, 0, 1, w1,    0);
        tbl[13] = mk(0, 0, 5'd0, 12'd0,   0,   1, 5'd2, 0, 0, 1, w1,    0);
        tbl[14] = mk(0, 0, 5'd0, 12'd0,   1,   1, 5'd2, 0, 0, 0, 32'd0, 0);
        tbl[15] = mk(0, 0, 5'd0, 12'd0,   1,   1, 5'd2, 0, 0, 0, 32'd0, 0);

        rst = 1'b1;
        command_ready_in = 1'b0; response_valid_in = 1'b0;
        response_channel_in = 5'd0; response_data_in = 12'd0; adc_ack_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", 32'(command_valid_out), 32'd0);
        check("rst_ch", 32'(command_channel_out), 32'd1);
        check("rst_sop", 32'(command_startofpacket_out), 32'd1);
        check("rst_eop", 32'(command_endofpacket_out), 32'd0);
        check("rst_stb", 32'(adc_stb_out), 32'd0);
        check("rst_out", adc_out, 32'd0);
        check("rst_ovf", 32'(overflow_out), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rdy, tbl[i].rv, tbl[i].rch, tbl[i].rd, tbl[i].ack);
            $display("row %0d ch=%0d sop=%0b eop=%0b stb=%0b out=%08h ovf=%0b", i,
                     command_channel_out, command_startofpacket_out, command_endofpacket_out,
                     adc_stb_out, adc_out, overflow_out);
            check($sformatf("row%0d_vld", i), 32'(command_valid_out), 32'(tbl[i].e_vld));
            check($sformatf("row%0d_ch", i), 32'(command_channel_out), 32'(tbl[i].e_ch));
            check($sformatf("row%0d_sop", i), 32'(command_startofpacket_out), 32'(tbl[i].e_sop));
            check($sformatf("row%0d_eop", i), 32'(command_endofpacket_out), 32'(tbl[i].e_eop));
            check($sformatf("row%0d_stb", i), 32'(adc_stb_out), 32'(tbl[i].e_stb));
            check($sformatf("row%0d_out", i), adc_out, tbl[i].e_out);
            check($sformatf("row%0d_ovf", i), 32'(overflow_out), 32'(tbl[i].e_ovf));
        end

        // Out-of-range channels 0 and 5 must never produce a word.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, (i % 2 == 1) ? 5'd5 : 5'd0, 12'(i * 100 + 7), 1'b1);
            check($sformatf("oor%0d_stb", i), 32'(adc_stb_out), 32'd0);
        end
        idle(1'b1);
        idle(1'b1);
        check("oor_stb_final", 32'(adc_stb_out), 32'd0);
        check("oor_ovf", 32'(overflow_out), 32'd0);

        // Nine windows into an eight-deep FIFO with no consumer.
        for (int w = 0; w < 9; w++) begin
            v = 16 * (w + 1);
            window(5'd1, v, v, v, v);
        end
        idle(1'b0);
        check("ovf_set", 32'(overflow_out), 32'd1);
        check("ovf_stb", 32'(adc_stb_out), 32'd1);
        for (int k = 0; k < 8; k++) begin
            v = 16 * (k + 1);
            $display("pop ovf k=%0d out=%08h ovf=%0b", k, adc_out, overflow_out);
            check($sformatf("ovf_pop%0d_out", k), adc_out, word(5'd1, k == 0, pk(v), v));
            check($sformatf("ovf_pop%0d_flag", k), 32'(overflow_out), 32'(k == 0));
            idle(1'b1);
        end
        check("ovf_drain_stb", 32'(adc_stb_out), 32'd0);
        check("ovf_drain_flag", 32'(overflow_out), 32'd0);

        // Full FIFO: push and pop land on the same edge.
        for (int w = 0; w < 9; w++) begin
            v = 32 * (w + 1);
            window(5'd4, v, v, v, v);
        end
        idle(1'b1);
        check("pp_ovf", 32'(overflow_out), 32'd0);
        check("pp_stb", 32'(adc_stb_out), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            v = 32 * (k + 1);
            $display("pop pp k=%0d out=%08h ovf=%0b", k, adc_out, overflow_out);
            check($sformatf("pp_pop%0d_out", k), adc_out, word(5'd4, 1'b0, pk(v), v));
            idle(1'b1);
        end
        check("pp_drain_stb", 32'(adc_stb_out), 32'd0);
        check("pp_drain_ovf", 32'(overflow_out), 32'd0);

        // Reset with a queued word and a half-filled window.
        window(5'd3, 40, 40, 40, 40);
        idle(1'b0);
        check("mid_stb_before", 32'(adc_stb_out), 32'd1);
        step(1'b0, 1'b1, 5'd2, 12'd200, 1'b0);
        step(1'b0, 1'b1, 5'd2, 12'd200, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_stb", 32'(adc_stb_out), 32'd0);
        check("mid_rst_out", adc_out, 32'd0);
        check("mid_rst_vld", 32'(command_valid_out), 32'd0);
        check("mid_rst_ch", 32'(command_channel_out), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1'b0);
        check("mid_vld", 32'(command_valid_out), 32'd1);
        window(5'd2, 8, 8, 8, 8);
        idle(1'b0);
        check("mid_word", adc_out, word(5'd2, 1'b0, pk(8), 8));
        idle(1'b1);
        check("mid_pop_stb", 32'(adc_stb_out), 32'd0);

        // Peak capture, including the full-scale sample.
        window(5'd3, 10, 4095, 20, 30);
        idle(1'b0);
        $display("peak out=%08h", adc_out);
        check("peak_word", adc_out, word(5'd3, 1'b0, pk(4095), (10 + 4095 + 20 + 30) >> 2));
        idle(1'b1);
        check("peak_pop_stb", 32'(adc_stb_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
